// File: rtl/cook_sequencer_pkg.sv
// Shared types and default constants for the microwave cook sequencer.
package cook_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int         COOK_TIME_W     = 13;
  localparam int         COOK_MAX_TIME   = 5999;
  localparam logic [4:0] COOK_TICK_SEL   = 5'd26;
  localparam int         COOK_BEEP_TICKS = 3;
  localparam int         BEEP_CNT_W      = 4;

endpackage

// File: rtl/cook_sequencer_tick_edge_det.sv
// Rising-edge detector on the divided tick; the history bit is cleared while the
// divider is being reset so the first second after a fresh start is a full period.
module tick_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic rise_o
);

  logic tick_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      tick_prev_q <= 1'b0;
    end else begin
      tick_prev_q <= tick_i;
    end
  end

  assign rise_o = tick_i & ~tick_prev_q;

endmodule

// File: rtl/cook_sequencer.sv
// Cook-cycle FSM: loads and counts down the cook time on divider ticks, pauses on
// door/stop, and holds a timed beep after completion. All outputs are registered.
module cook_sequencer
  import cook_sequencer_pkg::*;
#(
  parameter int         TIME_W     = COOK_TIME_W,
  parameter int         MAX_TIME   = COOK_MAX_TIME,
  parameter logic [4:0] TICK_SEL   = COOK_TICK_SEL,
  parameter int         BEEP_TICKS = COOK_BEEP_TICKS
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              door_open,
  input  logic [TIME_W-1:0] time_in,
  input  logic              tick_in,
  output logic              cm_en,
  output logic              cm_rst,
  output logic [4:0]        cm_sel,
  output logic              heater_on,
  output logic              beep,
  output logic [TIME_W-1:0] remaining,
  output logic [1:0]        state
);

  localparam logic [TIME_W-1:0]     ZERO_SEC  = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0]     ONE_SEC   = TIME_W'(1);
  localparam logic [TIME_W-1:0]     MAX_SEC   = TIME_W'(MAX_TIME);
  localparam logic [BEEP_CNT_W-1:0] BEEP_ZERO = {BEEP_CNT_W{1'b0}};
  localparam logic [BEEP_CNT_W-1:0] BEEP_ONE  = BEEP_CNT_W'(1);
  localparam logic [BEEP_CNT_W-1:0] BEEP_LOAD = BEEP_CNT_W'(BEEP_TICKS);

  state_e                  state_q, state_d;
  logic [TIME_W-1:0]       remaining_q, remaining_d;
  logic [BEEP_CNT_W-1:0]   beep_cnt_q, beep_cnt_d;
  logic                    heater_q, heater_d;
  logic                    beep_q, beep_d;
  logic                    cm_en_q, cm_en_d;
  logic                    cm_rst_q, cm_rst_d;
  logic [4:0]              cm_sel_q;
  logic                    tick_rise;

  tick_edge_det u_tick_edge_det (
    .clk_i  (sys_clk),
    .rst_i  (rst),
    .clr_i  (cm_rst_q),
    .tick_i (tick_in),
    .rise_o (tick_rise)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= ZERO_SEC;
      beep_cnt_q  <= BEEP_ZERO;
      heater_q    <= 1'b0;
      beep_q      <= 1'b0;
      cm_en_q     <= 1'b0;
      cm_rst_q    <= 1'b0;
      cm_sel_q    <= TICK_SEL;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beep_cnt_q  <= beep_cnt_d;
      heater_q    <= heater_d;
      beep_q      <= beep_d;
      cm_en_q     <= cm_en_d;
      cm_rst_q    <= cm_rst_d;
      cm_sel_q    <= TICK_SEL;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beep_cnt_d  = beep_cnt_q;
    heater_d    = heater_q;
    beep_d      = beep_q;
    cm_en_d     = cm_en_q;
    cm_rst_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        heater_d = 1'b0;
        beep_d   = 1'b0;
        cm_en_d  = 1'b0;
        if (start && !door_open && (time_in != ZERO_SEC)) begin
          state_d     = ST_RUN;
          remaining_d = (time_in > MAX_SEC) ? MAX_SEC : time_in;
          heater_d    = 1'b1;
          cm_en_d     = 1'b1;
          cm_rst_d    = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Pause takes priority; a tick landing on the same edge is dropped.
        if (door_open || stop) begin
          state_d  = ST_PAUSE;
          heater_d = 1'b0;
          cm_en_d  = 1'b0;
        end else if (tick_rise && (remaining_q != ZERO_SEC)) begin
          remaining_d = remaining_q - ONE_SEC;
          if (remaining_q == ONE_SEC) begin
            state_d    = ST_DONE;
            heater_d   = 1'b0;
            beep_d     = 1'b1;
            beep_cnt_d = BEEP_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          remaining_d = ZERO_SEC;
        end else if (start && !door_open) begin
          state_d  = ST_RUN;
          heater_d = 1'b1;
          cm_en_d  = 1'b1;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (stop || door_open) begin
          state_d    = ST_IDLE;
          beep_d     = 1'b0;
          beep_cnt_d = BEEP_ZERO;
          cm_en_d    = 1'b0;
        end else if (tick_rise && (beep_cnt_q != BEEP_ZERO)) begin
          beep_cnt_d = beep_cnt_q - BEEP_ONE;
          if (beep_cnt_q == BEEP_ONE) begin
            beep_d = 1'b0;
          end else begin
            beep_d = beep_q;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = ZERO_SEC;
        beep_cnt_d  = BEEP_ZERO;
        heater_d    = 1'b0;
        beep_d      = 1'b0;
        cm_en_d     = 1'b0;
      end
    endcase
  end

  assign cm_en     = cm_en_q;
  assign cm_rst    = cm_rst_q;
  assign cm_sel    = cm_sel_q;
  assign heater_on = heater_q;
  assign beep      = beep_q;
  assign remaining = remaining_q;
  assign state     = state_q;

endmodule
